uart_tx_fifo: RTL

Parametrised UART transmitter: next generation of the single-byte sender. Adds configurable data width, optional even/odd parity, 1 or 2 stop bits, an exact per-bit clock divider, and a small TX FIFO so the CPU/peripheral bus can queue several bytes without polling between them. Sits between the memory-mapped UART peripheral registers and the board TX pin; idle line high.

---
 rtl/uart_tx_fifo.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small TX FIFO, configurable framing and baud divider.
// Idle line high; frames are start, data LSB first, optional parity, stop bits.
module uart_tx_fifo #(
   parameter int DATA_BITS  = 8,
   parameter int BAUD_DIV   = 16,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [DATA_BITS-1:0]          TX_DATA,
   input  logic                          TX_EN,
   output logic                          TX_STATUS,
   output logic                          TX_BUSY,
   output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT,
   output logic                          UART_TX
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int DW = $clog2(BAUD_DIV);
   localparam int BW = $clog2(DATA_BITS);
   localparam logic ODD = (PARITY_ODD != 0);
   localparam logic PAR = (PARITY_EN != 0);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr;
   logic [AW-1:0]        rd_ptr;
   logic [CW-1:0]        count;
   logic [DATA_BITS-1:0] head;

   state_t               state;
   logic [DW-1:0]        div;
   logic [BW-1:0]        bit_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 par;

   logic push;
   logic pop;
   logic div_last;
   logic data_last;
   logic stop_last;
   logic frame_end;

   assign head       = mem[rd_ptr];
   assign TX_STATUS  = (count != CW'(FIFO_DEPTH));
   assign push       = TX_EN & TX_STATUS;
   assign div_last   = (div == DW'(BAUD_DIV - 1));
   assign data_last  = (bit_cnt == BW'(DATA_BITS - 1));
   assign stop_last  = (bit_cnt == BW'(STOP_BITS - 1));
   assign frame_end  = (state == STOP) & div_last & stop_last;
   assign pop        = (count != '0) & ((state == IDLE) | frame_end);
   assign TX_BUSY    = (state != IDLE) | (count != '0);
   assign FIFO_COUNT = count;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= TX_DATA;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Every bit period is BAUD_DIV cycles; the line only moves when div wraps.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         UART_TX <= 1'b1;
         div     <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
         par     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               UART_TX <= 1'b1;
               div     <= '0;
               bit_cnt <= '0;
               if (pop) begin
                  shreg   <= head;
                  par     <= (^head) ^ ODD;
                  UART_TX <= 1'b0;
                  state   <= START;
               end
            end
            START: begin
               if (div_last) begin
                  div     <= '0;
                  bit_cnt <= '0;
                  UART_TX <= shreg[0];
                  shreg   <= shreg >> 1;
                  state   <= DATA;
               end else begin
                  div <= div + DW'(1);
               end
            end
            DATA: begin
               if (div_last) begin
                  div <= '0;
                  if (data_last) begin
                     bit_cnt <= '0;
                     if (PAR) begin
                        UART_TX <= par;
                        state   <= PARITY;
                     end else begin
                        UART_TX <= 1'b1;
                        state   <= STOP;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + BW'(1);
                     UART_TX <= shreg[0];
                     shreg   <= shreg >> 1;
                  end
               end else begin
                  div <= div + DW'(1);
               end
            end
            PARITY: begin
               if (div_last) begin
                  div     <= '0;
                  bit_cnt <= '0;
                  UART_TX <= 1'b1;
                  state   <= STOP;
               end else begin
                  div <= div + DW'(1);
               end
            end
            STOP: begin
               if (div_last) begin
                  div <= '0;
                  if (stop_last) begin
                     bit_cnt <= '0;
                     // Queued word starts on the same edge: no idle gap.
                     if (pop) begin
                        shreg   <= head;
                        par     <= (^head) ^ ODD;
                        UART_TX <= 1'b0;
                        state   <= START;
                     end else begin
                        UART_TX <= 1'b1;
                        state   <= IDLE;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + BW'(1);
                  end
               end else begin
                  div <= div + DW'(1);
               end
            end
            default: begin
               state   <= IDLE;
               UART_TX <= 1'b1;
               div     <= '0;
               bit_cnt <= '0;
            end
         endcase
      end
   end

endmodule
